// File: rtl/core_pkg.sv
// Shared definitions for the segmented core's fetch front end.
//   XLEN      : datapath / address width
//   NOP_INST  : instruction shown to decode when no fetched word is available
//   PC_STEP   : byte distance between sequential instruction words
//   DROP_W    : width of the stale-response drop counter
//   fetch_entry_t : one buffered fetch result {inst, pc, pcinc}
package core_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0033;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Repeated redirects against a slow memory can leave more stale words in
    // flight than the FIFO depth, so the drop counter gets generous headroom.
    localparam int          DROP_W   = 8;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcinc;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used both for buffered fetch entries and for
// the PC tag queue of outstanding requests.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empty the FIFO next cycle (wins over push/pop)
//   push/push_data : write an entry; legal when full only together with pop
//   pop         : drop the head entry (ignored when empty)
//   head        : current head entry (undefined contents when empty)
//   full/empty/count : occupancy status
module fetch_fifo
    import core_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    push_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end feeding the decode-stage instruction register.
// Owns the fetch PC, requests words from instruction memory, buffers returned
// words with their PC and PC+4, and presents the oldest one to decode.
//
// Handshakes: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high; a head entry transfers on a cycle where
// inst_valid and inst_ready are both high; imem_resp_valid is a single-cycle
// strobe with no back-pressure, responses in request order.
//
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_req_valid/addr   : fetch request (word aligned)
//   imem_req_ready        : memory accepts the request
//   imem_resp_valid/data  : returned instruction word
//   redirect_valid/pc     : taken branch/jump, flushes everything in flight
//   inst_valid/data/pc/pcinc : head entry (NOP and zero PCs when empty)
//   inst_ready            : decode consumes the head (low on hazard stall)
module fetch_prefetch_buffer
    import core_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [XLEN-1:0]  imem_resp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             inst_valid,
    output logic [XLEN-1:0]  inst_data,
    output logic [XLEN-1:0]  inst_pc,
    output logic [XLEN-1:0]  inst_pcinc,
    input  logic             inst_ready
);

    localparam int CW = $clog2(DEPTH);

    logic [XLEN-1:0]   fetch_pc;
    logic [CW:0]       outstanding;   // live requests whose words will be kept
    logic [DROP_W-1:0] drop_cnt;      // stale words still to be discarded
    logic [CW+1:0]     credit_used;

    fetch_entry_t      inst_head;
    fetch_entry_t      push_entry;
    logic [XLEN-1:0]   tag_head;
    logic [CW:0]       inst_count;
    logic [CW:0]       tag_count;
    logic              inst_full, inst_empty, tag_full, tag_empty;

    logic              req_fire;
    logic              resp_keep;
    logic              resp_drop;
    logic              pop_fire;

    // Buffered entries plus requests still owed a word may never exceed the
    // FIFO depth, so every kept response is guaranteed a slot.
    assign credit_used    = {1'b0, inst_count} + {1'b0, outstanding};
    assign imem_req_valid = rst_n && !redirect_valid && (credit_used < (CW+2)'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_drop = imem_resp_valid && (drop_cnt != '0);
    assign resp_keep = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop_fire  = inst_valid && inst_ready && !redirect_valid;

    assign push_entry = '{inst: imem_resp_data, pc: tag_head, pcinc: tag_head + PC_STEP};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= word_align(RESET_PC);
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= word_align(redirect_pc);
            outstanding <= '0;
            // Everything still in flight becomes stale; a word arriving right
            // now is consumed by this cycle and needs no later drop.
            drop_cnt    <= drop_cnt + DROP_W'(outstanding) - DROP_W'(imem_resp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
            outstanding <= outstanding + (CW+1)'(req_fire) - (CW+1)'(resp_keep);
            if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (resp_keep),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_inst_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (resp_keep),
        .push_data (push_entry),
        .pop       (pop_fire),
        .head      (inst_head),
        .full      (inst_full),
        .empty     (inst_empty),
        .count     (inst_count)
    );

    assign inst_valid = !inst_empty;
    assign inst_data  = inst_valid ? inst_head.inst  : NOP_INST;
    assign inst_pc    = inst_valid ? inst_head.pc    : '0;
    assign inst_pcinc = inst_valid ? inst_head.pcinc : '0;

    // Every kept word must have a tag, and the tag queue tracks exactly the
    // live outstanding requests.
    tag_present_a: assert property (@(posedge clk) disable iff (!rst_n)
        resp_keep |-> !tag_empty);
    tag_count_a: assert property (@(posedge clk) disable iff (!rst_n)
        (tag_count == outstanding) && !(tag_full && req_fire && !resp_keep));
    inst_room_a: assert property (@(posedge clk) disable iff (!rst_n)
        (resp_keep && inst_full) |-> pop_fire);

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
module tb_fetch_prefetch_buffer;
    import core_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // main DUT (RESET_PC = 0)
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_req_addr, imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc, inst_pcinc;

    // wrap DUT (RESET_PC = FFFF_FFF8), zero-wait memory, always-ready decode
    logic        req_valid2, resp_valid2, inst_valid2;
    logic [31:0] req_addr2, resp_data2, inst_data2, inst_pc2, inst_pcinc2;

    fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_pcinc(inst_pcinc), .inst_ready(inst_ready)
    );

    fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid2), .imem_req_addr(req_addr2),
        .imem_req_ready(1'b1),
        .imem_resp_valid(resp_valid2), .imem_resp_data(resp_data2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(inst_valid2), .inst_data(inst_data2),
        .inst_pc(inst_pc2), .inst_pcinc(inst_pcinc2), .inst_ready(1'b1)
    );

    // ---------------- memory model / scoreboard state ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    int          cyc;
    int          lat;
    logic        pend2_v;
    logic [31:0] pend2_a;
    int          checks;
    int          errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at the falling edge with this cycle's inputs already set.
    task automatic tick_pre();
        logic [31:0] e;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
        resp_valid2 = pend2_v;
        resp_data2  = mem_word(pend2_a);
        #1;
        if (!inst_valid) begin
            chk("empty_data", inst_data, NOP_INST);
            chk("empty_pc", inst_pc, 32'h0);
            chk("empty_pcinc", inst_pcinc, 32'h0);
        end else if (inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_pop actual_pc=%h expected=none (cycle %0d)", inst_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", inst_pc, e);
                chk("sb_data", inst_data, mem_word(e));
                chk("sb_pcinc", inst_pcinc, e + 32'd4);
            end
        end
    endtask

    task automatic tick_post();
        if (imem_req_valid && imem_req_ready)
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
        pend2_v = req_valid2;
        pend2_a = req_addr2;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick();
        tick_pre();
        tick_post();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mq.delete();
        exp_q.delete();
        pend2_v = 1'b0;
        imem_resp_valid = 1'b0;
        resp_valid2 = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst_data", inst_data, NOP_INST);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_pcinc", inst_pcinc, 32'h0);
        chk("rst_inst_valid2", inst_valid2, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic run_until_drained(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 32'd0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_v2;
        logic [31:0] exp_pc2;
        logic [31:0] exp_inc2;
    } vec_t;

    vec_t vecs[6];

    initial begin
        checks = 0;
        errors = 0;
        lat = 1;
        cyc = 0;
        rst_n = 1'b0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b1;
        pend2_v = 1'b0;
        pend2_a = 32'h0;
        resp_valid2 = 1'b0;
        resp_data2 = 32'h0;

        //           rdy  valid pc          req   addr        v2    pc2           inc2
        vecs[0] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h0,        32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 1'b0, 32'h0,        32'h0};
        vecs[2] = '{1'b1, 1'b1, 32'h0,  1'b1, 32'h08, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
        vecs[3] = '{1'b1, 1'b1, 32'h4,  1'b1, 32'h0C, 1'b1, 32'hFFFF_FFFC, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h10, 1'b1, 32'h0,        32'h4};
        vecs[5] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h14, 1'b1, 32'h4,        32'h8};

        @(negedge clk);

        // Streaming from reset with a zero-wait memory, plus the wrapping PC.
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        for (int i = 0; i < 6; i++) begin
            inst_ready = vecs[i].ready;
            tick_pre();
            chk("t1_valid", inst_valid, vecs[i].exp_valid);
            chk("t1_pc", inst_pc, vecs[i].exp_pc);
            chk("t1_req_valid", imem_req_valid, vecs[i].exp_req);
            chk("t1_req_addr", imem_req_addr, vecs[i].exp_addr);
            chk("wrap_valid", inst_valid2, vecs[i].exp_v2);
            chk("wrap_pc", inst_pc2, vecs[i].exp_pc2);
            chk("wrap_pcinc", inst_pcinc2, vecs[i].exp_inc2);
            tick_post();
        end
        chk("t1_drained", exp_q.size(), 32'd0);

        // Decode stall: head held, fetch throttles at full, resume in order.
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_pre();
            chk("stall_valid", inst_valid, 1'b1);
            chk("stall_head", inst_pc, 32'h10);
            if (i >= 3) chk("stall_req_valid", imem_req_valid, 1'b0);
            tick_post();
        end
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(32'h10 + 32'(4 * k));
        run_until_drained("stall_resume_drain", 30);

        // Reset pulse with a full FIFO.
        inst_ready = 1'b0;
        repeat (6) tick();
        tick_pre();
        chk("full_valid", inst_valid, 1'b1);
        chk("full_req_valid", imem_req_valid, 1'b0);
        tick_post();
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        tick_pre();
        chk("restart_req_valid", imem_req_valid, 1'b1);
        chk("restart_addr", imem_req_addr, 32'h0);
        tick_post();
        run_until_drained("restart_drain", 20);

        // Latency 3, three in flight, redirect as the first stale word arrives.
        do_reset();
        lat = 3;
        for (int c = 0; c < 3; c++) begin
            tick_pre();
            chk("lat_addr", imem_req_addr, 32'(4 * c));
            tick_post();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick_pre();
        chk("redir_req_valid", imem_req_valid, 1'b0);
        tick_post();
        redirect_valid = 1'b0;
        tick_pre();
        chk("redir_addr", imem_req_addr, 32'h100);
        tick_post();
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        run_until_drained("redir_drain", 20);

        // Unaligned target, redirect coinciding with a response and a pop.
        do_reset();
        lat = 1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        tick_pre();
        chk("same_cycle_head", inst_pc, 32'h0);
        chk("same_cycle_resp", imem_resp_valid, 1'b1);
        chk("same_cycle_req_valid", imem_req_valid, 1'b0);
        tick_post();
        redirect_valid = 1'b0;
        tick_pre();
        chk("post_redir_valid", inst_valid, 1'b0);
        chk("post_redir_data", inst_data, 32'h0000_0033);
        chk("aligned_addr", imem_req_addr, 32'h200);
        tick_post();
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        run_until_drained("aligned_drain", 20);

        // Back-to-back redirects: last target wins, drops accumulate.
        do_reset();
        lat = 3;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h400;
        tick_pre();
        chk("dbl_req_valid", imem_req_valid, 1'b0);
        tick_post();
        redirect_valid = 1'b0;
        tick_pre();
        chk("dbl_addr", imem_req_addr, 32'h400);
        tick_post();
        exp_q.push_back(32'h400);
        exp_q.push_back(32'h404);
        run_until_drained("dbl_drain", 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
